// File: rtl/aline_tx_sequencer_pkg.sv
// Shared widths, FSM encoding and helpers for the A-line transmit sequencer.
// Imported by the top and by the per-channel pulse shifter.
package aline_tx_sequencer_pkg;

    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned DELAY_W    = 16;
    localparam int unsigned PULSE_W    = 32;
    localparam int unsigned T_W        = DELAY_W + 1;
    localparam int unsigned BIT_W      = $clog2(PULSE_W);
    localparam int unsigned MAX_ALINES = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitRd,
        StFire,
        StGap
    } state_e;

    function automatic logic [4:0] clamp_alines(input logic [4:0] sel);
        return (sel > 5'(MAX_ALINES)) ? 5'(MAX_ALINES) : sel;
    endfunction

endpackage

// File: rtl/aline_tx_sequencer_ch_pulse_shifter.sv
// One transmit channel: emits pulse_shape MSB first, starting when t reaches this
// channel's delay. The output bit is registered, so it lags t by one cycle.
module aline_tx_sequencer_ch_pulse_shifter
    import aline_tx_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [T_W-1:0]     t,
    input  logic [DELAY_W-1:0] delay,
    input  logic               enable,
    input  logic [PULSE_W-1:0] pulse_shape,
    output logic               tx
);

    logic [T_W-1:0]   offset;
    logic [BIT_W-1:0] bit_idx;
    logic             in_win;
    logic             tx_d;
    logic             tx_q;

    always_comb begin
        offset  = t - {1'b0, delay};
        in_win  = (t >= {1'b0, delay}) && (offset < T_W'(PULSE_W));
        bit_idx = BIT_W'(PULSE_W - 1) - offset[BIT_W-1:0];
        tx_d    = enable && in_win && pulse_shape[bit_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/aline_tx_sequencer.sv
// A-line transmit sequencer: requests per-channel delays for each A-line, waits for the
// read-back, fires the pulse on every enabled channel, then idles GAP_CYC cycles.
module aline_tx_sequencer
    import aline_tx_sequencer_pkg::*;
#(
    parameter int unsigned GAP_CYC = 1000,
    parameter int unsigned RD_TMO  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               intaking_configs,
    input  logic               updating_delays,
    input  logic [NUM_CH-1:0]  channel_select,
    input  logic [4:0]         aline_select,
    input  logic [PULSE_W-1:0] pulse_shape,
    input  logic [DELAY_W-1:0] ch0delay,
    input  logic [DELAY_W-1:0] ch1delay,
    input  logic [DELAY_W-1:0] ch2delay,
    input  logic [DELAY_W-1:0] ch3delay,
    input  logic [DELAY_W-1:0] ch4delay,
    input  logic [DELAY_W-1:0] ch5delay,
    input  logic [DELAY_W-1:0] ch6delay,
    input  logic [DELAY_W-1:0] ch7delay,
    output logic               rd_en,
    output logic [3:0]         which_aline,
    output logic [NUM_CH-1:0]  tx_out,
    output logic               busy,
    output logic               aline_done,
    output logic               image_done,
    output logic               rd_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
    localparam int unsigned TMO_W = $clog2(RD_TMO + 1);

    state_e               state_q, state_d;
    logic [3:0]           which_q, which_d;
    logic [4:0]           n_alines_q, n_alines_d;
    logic [NUM_CH-1:0]    chan_q, chan_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [DELAY_W-1:0]   delay_q [NUM_CH];
    logic [DELAY_W-1:0]   delay_d [NUM_CH];
    logic [DELAY_W-1:0]   delay_in [NUM_CH];
    logic [T_W-1:0]       t_q, t_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 seen_q, seen_d;
    logic                 rd_err_q, rd_err_d;
    logic                 aline_done_q, aline_done_d;
    logic                 image_done_q, image_done_d;
    logic [DELAY_W-1:0]   max_delay;
    logic                 fire_last;
    logic                 fire_en;

    always_comb begin
        delay_in[0] = ch0delay;
        delay_in[1] = ch1delay;
        delay_in[2] = ch2delay;
        delay_in[3] = ch3delay;
        delay_in[4] = ch4delay;
        delay_in[5] = ch5delay;
        delay_in[6] = ch6delay;
        delay_in[7] = ch7delay;
    end

    // Only enabled channels stretch the FIRE window; none enabled leaves maxD at 0.
    always_comb begin
        max_delay = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan_q[i] && (delay_q[i] > max_delay)) begin
                max_delay = delay_q[i];
            end
        end
    end

    assign fire_last = (t_q == ({1'b0, max_delay} + T_W'(PULSE_W - 1)));
    assign fire_en   = (state_q == StFire) && !intaking_configs;

    always_comb begin
        state_d      = state_q;
        which_d      = which_q;
        n_alines_d   = n_alines_q;
        chan_d       = chan_q;
        pulse_d      = pulse_q;
        delay_d      = delay_q;
        t_d          = t_q;
        gap_d        = gap_q;
        tmo_d        = tmo_q;
        seen_d       = seen_q;
        rd_err_d     = rd_err_q;
        aline_done_d = 1'b0;
        image_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !intaking_configs) begin
                    chan_d     = channel_select;
                    pulse_d    = pulse_shape;
                    n_alines_d = clamp_alines(aline_select);
                    rd_err_d   = 1'b0;
                    which_d    = '0;
                    if (clamp_alines(aline_select) == 5'd0) begin
                        image_done_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                tmo_d   = '0;
                seen_d  = 1'b0;
                state_d = StWaitRd;
            end
            StWaitRd: begin
                if (seen_q && !updating_delays) begin
                    delay_d = delay_in;
                    t_d     = '0;
                    state_d = StFire;
                end else if (tmo_q == TMO_W'(RD_TMO - 1)) begin
                    rd_err_d = 1'b1;
                    state_d  = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (updating_delays) begin
                        seen_d = 1'b1;
                    end
                end
            end
            StFire: begin
                if (fire_last) begin
                    aline_done_d = 1'b1;
                    gap_d        = '0;
                    state_d      = StGap;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    if (({1'b0, which_q} + 5'd1) < n_alines_q) begin
                        which_d = which_q + 1'b1;
                        state_d = StReq;
                    end else begin
                        image_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Config reload wins over everything and leaves rd_err as it was.
        if ((state_q != StIdle) && intaking_configs) begin
            state_d      = StIdle;
            rd_err_d     = rd_err_q;
            aline_done_d = 1'b0;
            image_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            which_q      <= '0;
            n_alines_q   <= '0;
            chan_q       <= '0;
            pulse_q      <= '0;
            t_q          <= '0;
            gap_q        <= '0;
            tmo_q        <= '0;
            seen_q       <= 1'b0;
            rd_err_q     <= 1'b0;
            aline_done_q <= 1'b0;
            image_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            which_q      <= which_d;
            n_alines_q   <= n_alines_d;
            chan_q       <= chan_d;
            pulse_q      <= pulse_d;
            t_q          <= t_d;
            gap_q        <= gap_d;
            tmo_q        <= tmo_d;
            seen_q       <= seen_d;
            rd_err_q     <= rd_err_d;
            aline_done_q <= aline_done_d;
            image_done_q <= image_done_d;
            delay_q      <= delay_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        aline_tx_sequencer_ch_pulse_shifter u_shifter (
            .clk         (clk),
            .rst         (rst),
            .t           (t_q),
            .delay       (delay_q[i]),
            .enable      (fire_en && chan_q[i]),
            .pulse_shape (pulse_q),
            .tx          (tx_out[i])
        );
    end

    assign rd_en       = (state_q == StReq);
    assign busy        = (state_q != StIdle);
    assign which_aline = which_q;
    assign aline_done  = aline_done_q;
    assign image_done  = image_done_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_aline_tx_sequencer.sv
// Directed bench for aline_tx_sequencer: a table of image configurations against a small
// config-store responder, plus hand sequences for timeout, abort and asynchronous reset.
module tb_aline_tx_sequencer;

    localparam int GAP = 100;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        intaking_configs = 1'b0;
    logic        updating_delays = 1'b0;
    logic [7:0]  channel_select = '0;
    logic [4:0]  aline_select = '0;
    logic [31:0] pulse_shape = '0;
    logic [15:0] ch0delay = '0;
    logic [15:0] ch1delay = '0;
    logic [15:0] ch2delay = '0;
    logic [15:0] ch3delay = '0;
    logic [15:0] ch4delay = '0;
    logic [15:0] ch5delay = '0;
    logic [15:0] ch6delay = '0;
    logic [15:0] ch7delay = '0;
    logic        rd_en;
    logic [3:0]  which_aline;
    logic [7:0]  tx_out;
    logic        busy;
    logic        aline_done;
    logic        image_done;
    logic        rd_err;

    aline_tx_sequencer #(
        .GAP_CYC (GAP),
        .RD_TMO  (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .intaking_configs (intaking_configs),
        .updating_delays  (updating_delays),
        .channel_select   (channel_select),
        .aline_select     (aline_select),
        .pulse_shape      (pulse_shape),
        .ch0delay         (ch0delay),
        .ch1delay         (ch1delay),
        .ch2delay         (ch2delay),
        .ch3delay         (ch3delay),
        .ch4delay         (ch4delay),
        .ch5delay         (ch5delay),
        .ch6delay         (ch6delay),
        .ch7delay         (ch7delay),
        .rd_en            (rd_en),
        .which_aline      (which_aline),
        .tx_out           (tx_out),
        .busy             (busy),
        .aline_done       (aline_done),
        .image_done       (image_done),
        .rd_err           (rd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: event counters and a tx log indexed by cycles since the read-back finished.
    int          rd_cnt = 0;
    int          ad_cnt = 0;
    int          id_cnt = 0;
    int          ad_cyc = 0;
    int          id_cyc = 0;
    int          fall_cyc = -100000;
    int          fire_len = 0;
    logic [3:0]  rd_which [$];
    logic [7:0]  txlog [64];

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cnt++;
            rd_which.push_back(which_aline);
        end
        if (aline_done) begin
            ad_cnt++;
            ad_cyc   = cyc;
            fire_len = cyc - fall_cyc - 1;
        end
        if (image_done) begin
            id_cnt++;
            id_cyc = cyc;
        end
        if ((cyc - fall_cyc >= 0) && (cyc - fall_cyc < 64)) begin
            txlog[cyc - fall_cyc] = tx_out;
        end
    end

    // Config store stand-in: two cycles after rd_en, hold updating_delays high for three.
    logic respond_en = 1'b1;
    initial forever begin
        @(negedge clk);
        if (rd_en && respond_en) begin
            repeat (2) @(negedge clk);
            updating_delays = 1'b1;
            repeat (3) @(negedge clk);
            updating_delays = 1'b0;
            fall_cyc = cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0]  asel;
        logic [7:0]  chan;
        logic [31:0] pulse;
        logic [15:0] d0;
        logic [15:0] d7;
        int          exp_rd;
        int          exp_fire;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [7:0] exp_tx(input vec_t v, input int t);
        logic [7:0] r;
        int         d;
        r = '0;
        for (int ch = 0; ch < 8; ch++) begin
            d = (ch == 0) ? int'(v.d0) : ((ch == 7) ? int'(v.d7) : 0);
            if (v.chan[ch] && (t >= d) && (t < d + 32)) begin
                r[ch] = v.pulse[31 - (t - d)];
            end
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int rd0, ad0, id0, q0, budget, waited, s;
        rd0 = rd_cnt;
        ad0 = ad_cnt;
        id0 = id_cnt;
        q0  = rd_which.size();
        aline_select   = v.asel;
        channel_select = v.chan;
        pulse_shape    = v.pulse;
        ch0delay       = v.d0;
        ch7delay       = v.d7;
        budget = v.exp_rd * (GAP + v.exp_fire + 50) + 200;
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        waited = 1;
        while ((id_cnt == id0) && (waited < budget)) begin
            tick();
            waited++;
        end
        check($sformatf("v%0d_image_done_count", idx), id_cnt - id0, 1);
        check($sformatf("v%0d_rd_en_count", idx), rd_cnt - rd0, v.exp_rd);
        check($sformatf("v%0d_aline_done_count", idx), ad_cnt - ad0, v.exp_rd);
        check($sformatf("v%0d_busy_after", idx), busy, 0);
        for (int j = 0; j < v.exp_rd; j++) begin
            check($sformatf("v%0d_which_aline_%0d", idx, j),
                  (q0 + j < rd_which.size()) ? rd_which[q0 + j] : 4'hx, j);
        end
        if (v.exp_rd == 0) begin
            check($sformatf("v%0d_image_done_latency", idx), id_cyc - s, 1);
        end else begin
            check($sformatf("v%0d_fire_len", idx), fire_len, v.exp_fire);
            check($sformatf("v%0d_gap_len", idx), id_cyc - ad_cyc, GAP);
            if (v.exp_fire + 4 <= 64) begin
                for (int k = 1; k <= v.exp_fire + 3; k++) begin
                    check($sformatf("v%0d_tx_k%0d", idx, k), txlog[k], exp_tx(v, k - 2));
                end
            end
        end
    endtask

    initial begin
        int n, ad0, id0, rd0;

        vecs[0] = '{5'd1,  8'h01, 32'hA000_0001, 16'd0, 16'd0,     1,  32};
        vecs[1] = '{5'd3,  8'h81, 32'hB3C5_0F81, 16'd5, 16'd10,    3,  42};
        vecs[2] = '{5'd0,  8'h01, 32'hA000_0001, 16'd0, 16'd0,     0,  0};
        vecs[3] = '{5'd2,  8'h00, 32'hFFFF_FFFF, 16'd7, 16'd9,     2,  32};
        vecs[4] = '{5'd20, 8'h3C, 32'hC3C3_0F0F, 16'd0, 16'd0,     16, 32};
        vecs[5] = '{5'd1,  8'h80, 32'h8000_0001, 16'd0, 16'hFFFF,  1,  65567};

        // Reset values while rst is held low.
        #2 rst = 1'b0;
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_which_aline", which_aline, 0);
        check("rst_tx_out", tx_out, 0);
        check("rst_busy", busy, 0);
        check("rst_aline_done", aline_done, 0);
        check("rst_image_done", image_done, 0);
        check("rst_rd_err", rd_err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            repeat (3) tick();
        end

        // Read-back never arrives: rd_err after 64 WAIT_RD cycles, no image_done.
        respond_en     = 1'b0;
        aline_select   = 5'd1;
        channel_select = 8'h01;
        ch0delay       = 16'd0;
        ch7delay       = 16'd0;
        id0 = id_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!rd_en && (n < 10)) begin
            tick();
            n++;
        end
        check("tmo_rd_en_seen", rd_en, 1);
        n = 0;
        while (!rd_err && (n < 100)) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 65);
        check("tmo_rd_err", rd_err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_no_image_done", id_cnt - id0, 0);
        respond_en = 1'b1;
        tick();

        // Start while intaking_configs is ignored and keeps the sticky error.
        rd0 = rd_cnt;
        intaking_configs = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", busy, 0);
        check("ign_rd_err", rd_err, 1);
        tick();
        check("ign_no_rd_en", rd_cnt - rd0, 0);
        intaking_configs = 1'b0;
        tick();

        // An accepted start clears the error.
        aline_select = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr_rd_err", rd_err, 0);
        tick();

        // Abort mid-FIRE.
        aline_select   = 5'd1;
        channel_select = 8'hFF;
        pulse_shape    = 32'hFFFF_FFFF;
        ad0 = ad_cnt;
        id0 = id_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!updating_delays && (n < 20)) begin
            tick();
            n++;
        end
        n = 0;
        while (updating_delays && (n < 20)) begin
            tick();
            n++;
        end
        repeat (9) tick();
        check("abort_pre_tx", tx_out, 8'hFF);
        check("abort_pre_busy", busy, 1);
        intaking_configs = 1'b1;
        tick();
        check("abort_tx", tx_out, 8'h00);
        check("abort_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_start_ignored", busy, 0);
        intaking_configs = 1'b0;
        repeat (40) tick();
        check("abort_no_aline_done", ad_cnt - ad0, 0);
        check("abort_no_image_done", id_cnt - id0, 0);
        check("abort_rd_err", rd_err, 0);

        // Asynchronous reset in the GAP of the second A-line.
        aline_select   = 5'd2;
        channel_select = 8'h01;
        pulse_shape    = 32'hA000_0001;
        ad0 = ad_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while ((ad_cnt - ad0 < 2) && (n < 2 * (GAP + 100) + 200)) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("gaprst_pre_which", which_aline, 1);
        check("gaprst_pre_busy", busy, 1);
        #1 rst = 1'b0;
        #1;
        check("gaprst_busy", busy, 0);
        check("gaprst_which_aline", which_aline, 0);
        check("gaprst_rd_en", rd_en, 0);
        check("gaprst_tx_out", tx_out, 0);
        check("gaprst_image_done", image_done, 0);
        tick();
        rst = 1'b1;
        tick();
        check("gaprst_after_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
